// File: rtl/mix_digest_fold.sv
// Folds 256-bit state snapshots word by word into a 32-bit rotate-xor digest.
// Latency: accept edge plus 8 fold edges per snapshot. out_valid rises after the 8th fold of the VECTORS-th snapshot.
// Backpressure: in_ready is low while folding or emitting. The digest holds in EMIT until out_ready.
//
// Ports:
//   clk, rst                   single clock; asynchronous active-high reset
//   in_valid/in_ready/in_data  snapshot input; word i at bits [32i+31:32i]
//   out_valid/out_ready        digest output handshake
//   out_digest                 completed 32-bit digest
//   busy                       high while folding
module mix_digest_fold #(
    parameter int          VECTORS = 4,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter int          ROT     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_digest,
    output logic         busy
);

    // A vector count of 1 would give a zero-width counter, so keep at least one bit.
    localparam int CW = (VECTORS > 1) ? $clog2(VECTORS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [255:0]    r_buf;
    logic [31:0]     r_acc;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_vec_cnt;
    logic [31:0]     r_digest;

    logic [31:0]     w_word;
    logic [31:0]     w_rot;
    logic [31:0]     w_fold;
    logic            w_last_word;
    logic            w_last_vec;
    logic            w_in_fire;
    logic            w_out_fire;

    // Word select: idx*32 is formed by concatenation to keep the offset 8 bits wide.
    assign w_word      = r_buf[{r_idx, 5'b00000} +: 32];
    assign w_rot       = (r_acc << ROT) | (r_acc >> (32 - ROT));
    assign w_fold      = w_rot ^ w_word;
    assign w_last_word = (r_idx == 3'd7);
    assign w_last_vec  = (r_vec_cnt == CW'(VECTORS - 1));
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;

    assign out_digest  = r_digest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_FOLD;
                end
            end
            S_FOLD: begin
                busy = 1'b1;
                if (w_last_word) begin
                    w_next_state = w_last_vec ? S_EMIT : S_IDLE;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf     <= '0;
            r_acc     <= SEED;
            r_idx     <= '0;
            r_vec_cnt <= '0;
            r_digest  <= '0;
        end else begin
            if (w_in_fire) begin
                r_buf <= in_data;
                r_idx <= '0;
            end
            if (r_state == S_FOLD) begin
                r_acc <= w_fold;
                r_idx <= r_idx + 3'd1;
                if (w_last_word) begin
                    if (w_last_vec) begin
                        r_vec_cnt <= '0;
                        // Digest captures the same value the accumulator takes on this edge.
                        r_digest  <= w_fold;
                    end else begin
                        r_vec_cnt <= r_vec_cnt + 1'b1;
                    end
                end
            end
            if (w_out_fire) begin
                r_acc <= SEED;
            end
        end
    end

endmodule

// File: doc/mix_digest_fold.md
# mix_digest_fold

Downstream consumer of the 8×32-bit mixing stage. It accepts one 256-bit state snapshot (words o0..o7) per handshake and folds the words serially, one per clock, into a 32-bit rotate-xor accumulator. After `VECTORS` snapshots it presents the 32-bit digest on a valid/ready output and restarts. This lets the mixing core's output be checked and compared without exporting all 256 bits.

## Interface
- `VECTORS`, default 4: number of snapshots folded per digest. Must be ≥1.
- `SEED`, default 32'h0000_0001: accumulator value after reset and after each emitted digest.
- `ROT`, default 5: left-rotate amount per fold step, in the range 1..31.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input, 1: single clock; all state updates on its posedge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: a snapshot is offered on `in_data`.
- `in_ready` output, 1: the block can accept a snapshot.
- `in_data` input, 256: word i (oi) sits at bits [32i+31:32i]; o0 is the least significant word.
- `out_valid` output, 1: `out_digest` is valid.
- `out_ready` input, 1: the consumer accepts the digest.
- `out_digest` output, 32: the completed digest.
- `busy` output, 1: high while in FOLD.

## Operation
- FSM states are IDLE, FOLD and EMIT. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_data` into a 256-bit buffer, clear word index idx=0, and go to FOLD.
- FOLD:
  - `in_ready`=0, `busy`=1.
  - Each cycle: acc ← rotl(acc, ROT) ^ buf_word[idx]; idx ← idx+1.
  - Words are folded in order o0 first, o7 last.
  - On the edge that folds idx=7:
    - If vec_cnt==VECTORS-1: vec_cnt←0, load `out_digest` with the final acc (same value as the acc update), go to EMIT.
    - Otherwise: vec_cnt←vec_cnt+1, go to IDLE.
- EMIT:
  - `out_valid`=1, `in_ready`=0.
  - On `out_ready`: acc←SEED and go to IDLE.
  - `out_digest` and `out_valid` stay stable until accepted.
- Arithmetic:
  - rotl is a pure 32-bit rotate; no carries, no width growth.
  - vec_cnt is wide enough for VECTORS-1 and wraps only through the rule above.
- `in_data` is sampled only at the accept edge. Changes while FOLD or EMIT have no effect.
- `in_valid` while `in_ready`=0 is ignored (not queued). The upstream must hold it.

## Timing
- Reset values:
  - state=IDLE, acc=SEED, vec_cnt=0, idx=0.
  - `in_ready`=1 (combinational from state; 1 after reset deasserts).
  - `out_valid`=0, `busy`=0, `out_digest`=0.
- Reset asserted at any point aborts the operation immediately. The partial acc and the count are discarded, and `out_valid` drops asynchronously.
- Accept at edge E0, then fold at edges E1..E8. `in_ready` or `out_valid` rises after E8. The earliest next accept is E9, giving 1 snapshot per 9 cycles.
- Digest latency: `out_valid` is high in the cycle after the 8th fold of the VECTORS-th snapshot.
- Handshakes complete only on a posedge with both valid and ready high.
- `out_ready` high in the first EMIT cycle means a 1-cycle EMIT. IDLE follows, and a new accept is possible on the next edge.
- If `out_ready` is held high permanently, there is no bubble beyond the 1 EMIT cycle.
- `in_ready` is never high while in EMIT, so there is no simultaneous in/out handshake.

## Test plan
- VECTORS=1, SEED=0, `in_data` has o0=1 and all other words 0 → `out_digest`=32'h0000_0008, with `out_valid` rising 9 cycles after accept.
- VECTORS=1, SEED=0, o7=32'h1234_5678 and the rest 0 → `out_digest`=32'h1234_5678.
- VECTORS=1, SEED=1, all-zero snapshot → 32'h0000_0100. Then a second all-zero snapshot → 32'h0000_0100 again, confirming acc reloads SEED after emit.
- Default parameters (VECTORS=4, SEED=1, ROT=5):
  - Four all-zero snapshots → 32'h0000_0001.
  - `in_ready` is low during each 8-cycle fold.
  - `out_valid` is asserted only after the 4th snapshot.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles during EMIT → `out_valid` and `out_digest` stay stable and `in_ready` stays 0.
  - Toggle `in_data` during that window → no effect on the next digest.
- Assert `rst` during FOLD of the 2nd snapshot (VECTORS=4) → outputs return to reset values at once. A subsequent 4-zero-snapshot run then yields 32'h0000_0001.
